// File: rtl/udm_host_pkg.sv
// Shared constants, FSM state type and frame byte helper for the UART debug-bus host initiator.
package udm_host_pkg;

    localparam logic [7:0] UDM_SYNC    = 8'h55;
    localparam logic [7:0] UDM_CMD_WR  = 8'h81;
    localparam logic [7:0] UDM_CMD_RD  = 8'h80;
    localparam logic [7:0] UDM_LEN_LSB = 8'h04;

    localparam int WR_FRAME_BYTES = 14;
    localparam int RD_FRAME_BYTES = 10;
    localparam int RESP_BYTES     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RECV = 2'd2,
        ST_DONE = 2'd3
    } udm_state_e;

    // Byte idx of an outgoing frame: sync, command, address LSB first,
    // fixed one-word length, then write data LSB first (writes only).
    function automatic logic [7:0] udm_frame_byte(
        input logic [3:0]  idx,
        input logic        we,
        input logic [31:0] addr,
        input logic [31:0] wdata
    );
        logic [7:0] b;
        case (idx)
            4'd0:    b = UDM_SYNC;
            4'd1:    b = we ? UDM_CMD_WR : UDM_CMD_RD;
            4'd2:    b = addr[7:0];
            4'd3:    b = addr[15:8];
            4'd4:    b = addr[23:16];
            4'd5:    b = addr[31:24];
            4'd6:    b = UDM_LEN_LSB;
            4'd10:   b = wdata[7:0];
            4'd11:   b = wdata[15:8];
            4'd12:   b = wdata[23:16];
            4'd13:   b = wdata[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/udm_uart_phy.sv
// Byte-level 8N1 UART, LSB first. TX accepts a new byte in the last cycle of the
// previous stop bit so consecutive bytes go out with no idle gap. RX samples the
// synchronised line at mid-bit and flags a low stop bit as a framing error.
module udm_uart_phy #(
    parameter int BIT_CYC = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_line,
    input  logic       rx_line,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_ferr
);

    localparam int CW = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
    localparam logic [CW-1:0] BIT_LOAD  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_CYC / 2);

    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [9:0]    tx_sh;
    logic          tx_busy_q;
    logic          tx_line_q;

    logic          rx_s1, rx_s2, rx_s3;
    logic          rx_busy;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_sh;
    logic          rx_valid_q;
    logic          rx_ferr_q;

    assign tx_busy  = tx_busy_q;
    assign tx_done  = tx_busy_q && (tx_cnt == '0) && (tx_bit == 4'd9);
    assign tx_line  = tx_line_q;
    assign rx_valid = rx_valid_q;
    assign rx_byte  = rx_sh;
    assign rx_ferr  = rx_ferr_q;

    // TX shifter: start + 8 data + stop, each held for BIT_CYC cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_sh     <= '1;
            tx_busy_q <= 1'b0;
            tx_line_q <= 1'b1;
        end else if (tx_start && (!tx_busy_q || tx_done)) begin
            tx_sh     <= {1'b1, tx_byte, 1'b0};
            tx_busy_q <= 1'b1;
            tx_cnt    <= BIT_LOAD;
            tx_bit    <= 4'd0;
            tx_line_q <= 1'b0;
        end else if (tx_busy_q) begin
            if (tx_cnt == '0) begin
                if (tx_bit == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    tx_line_q <= 1'b1;
                end else begin
                    tx_bit    <= tx_bit + 4'd1;
                    tx_cnt    <= BIT_LOAD;
                    tx_sh     <= {1'b1, tx_sh[9:1]};
                    tx_line_q <= tx_sh[1];
                end
            end else begin
                tx_cnt <= tx_cnt - CW'(1);
            end
        end
    end

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx_line;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // RX sampler: first sample lands mid start bit, then one sample per bit period.
    // Going idle at mid stop bit lets the next start edge be caught back-to-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_busy    <= 1'b0;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_sh      <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (!rx_busy) begin
                if (rx_s3 && !rx_s2) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= HALF_LOAD;
                    rx_bit  <= 4'd0;
                end
            end else if (rx_cnt == '0) begin
                rx_cnt <= BIT_LOAD;
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit == 4'd0) begin
                    // a start bit that is high again by mid-bit was a glitch
                    if (rx_s2) begin
                        rx_busy <= 1'b0;
                    end
                end else if (rx_bit == 4'd9) begin
                    rx_valid_q <= 1'b1;
                    rx_ferr_q  <= !rx_s2;
                    rx_busy    <= 1'b0;
                end else begin
                    rx_sh <= {rx_s2, rx_sh[7:1]};
                end
            end else begin
                rx_cnt <= rx_cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/udm_host_initiator.sv
// Host-side initiator for the UART debug bus: takes one bus command at a time on a
// req/ack port, sends it as a byte frame and, for reads, collects the 4-byte reply.
//
// state | meaning
// IDLE  | waiting for cmd_req_i
// SEND  | streaming frame bytes back to back
// RECV  | collecting read response bytes under a timeout
// DONE  | one-cycle completion pulse
module udm_host_initiator
    import udm_host_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 25000000,
    parameter int BAUD_RATE    = 921600,
    parameter int RESP_TIMEOUT = 1000000
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic        cmd_req_i,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        cmd_ack_o,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        busy_o,
    input  logic        rx_i,
    output logic        tx_o
);

    localparam int BIT_CYC = CLK_FREQ_HZ / BAUD_RATE;
    localparam int TO_W    = $clog2(RESP_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(RESP_TIMEOUT - 1);

    udm_state_e    state, state_next;

    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    byte_idx;
    logic [3:0]    frame_len;
    logic [1:0]    rx_idx;
    logic [TO_W-1:0] to_cnt;
    logic [31:0]   asm_q;
    logic [31:0]   asm_next;
    logic          err_q;
    logic          ack_q;

    logic          tx_start;
    logic [7:0]    tx_byte;
    logic          tx_busy;
    logic          tx_done;
    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic          rx_ferr;
    logic          byte_take;
    logic          fail;

    udm_uart_phy #(
        .BIT_CYC (BIT_CYC)
    ) u_phy (
        .clk      (clk_i),
        .rst      (arst_i),
        .tx_start (tx_start),
        .tx_byte  (tx_byte),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_line  (tx_o),
        .rx_line  (rx_i),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .rx_ferr  (rx_ferr)
    );

    assign frame_len    = we_q ? 4'(WR_FRAME_BYTES) : 4'(RD_FRAME_BYTES);
    assign tx_byte      = udm_frame_byte(byte_idx, we_q, addr_q, wdata_q);
    assign cmd_ack_o    = ack_q;
    assign resp_valid_o = (state == ST_DONE);
    assign resp_err_o   = (state == ST_DONE) && err_q;
    assign busy_o       = (state != ST_IDLE);

    // Next-state, byte launch and response accept decisions.
    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        byte_take  = 1'b0;
        fail       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_req_i) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (byte_idx != frame_len) begin
                    if (!tx_busy || tx_done) begin
                        tx_start = 1'b1;
                    end
                end else if (tx_done) begin
                    state_next = we_q ? ST_DONE : ST_RECV;
                end
            end
            ST_RECV: begin
                if (rx_valid) begin
                    if (rx_ferr) begin
                        fail       = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        byte_take = 1'b1;
                        if (rx_idx == 2'(RESP_BYTES - 1)) begin
                            state_next = ST_DONE;
                        end
                    end
                end else if (to_cnt == '0) begin
                    fail       = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Response assembly, LSB byte first.
    always_comb begin
        asm_next = asm_q;
        if (byte_take) begin
            case (rx_idx)
                2'd0:    asm_next[7:0]   = rx_byte;
                2'd1:    asm_next[15:8]  = rx_byte;
                2'd2:    asm_next[23:16] = rx_byte;
                default: asm_next[31:24] = rx_byte;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command latch, byte/response counters, timeout and result registers.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ack_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            byte_idx     <= '0;
            rx_idx       <= '0;
            to_cnt       <= '0;
            asm_q        <= '0;
            err_q        <= 1'b0;
            resp_rdata_o <= '0;
        end else begin
            ack_q <= (state == ST_IDLE) && cmd_req_i;

            if ((state == ST_IDLE) && cmd_req_i) begin
                we_q     <= cmd_we_i;
                addr_q   <= cmd_addr_i;
                wdata_q  <= cmd_wdata_i;
                byte_idx <= '0;
                rx_idx   <= '0;
                asm_q    <= '0;
                err_q    <= 1'b0;
            end

            if (tx_start) begin
                byte_idx <= byte_idx + 4'd1;
            end

            if ((state == ST_SEND) && (state_next == ST_RECV)) begin
                to_cnt <= TO_LOAD;
            end else if (state == ST_RECV) begin
                if (byte_take) begin
                    to_cnt <= TO_LOAD;
                end else if (to_cnt != '0) begin
                    to_cnt <= to_cnt - TO_W'(1);
                end
            end

            if (byte_take) begin
                asm_q  <= asm_next;
                rx_idx <= rx_idx + 2'd1;
            end

            if (fail) begin
                err_q <= 1'b1;
            end

            // only a finishing read replaces the visible read data
            if ((state == ST_RECV) && (state_next == ST_DONE)) begin
                resp_rdata_o <= asm_next;
            end
        end
    end

endmodule

// File: tb/tb_udm_host_initiator.sv
// Directed bench for udm_host_initiator: decodes tx_o, plays target replies on rx_i.
module tb_udm_host_initiator;

    localparam int BIT_CYC = 27;   // 25_000_000 / 921_600

    logic        clk = 1'b0;
    logic        arst_i = 1'b1;
    logic        cmd_req_i = 1'b0;
    logic        cmd_we_i = 1'b0;
    logic [31:0] cmd_addr_i = '0;
    logic [31:0] cmd_wdata_i = '0;
    logic        cmd_ack_o;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        busy_o;
    logic        rx_i = 1'b1;
    logic        tx_o;

    int n_chk = 0;
    int n_pass = 0;

    int cyc = 0;
    int ack_cnt = 0;
    int ack_cyc = 0;
    int valid_cnt = 0;
    int valid_cyc = 0;
    logic        valid_err = 1'b0;
    logic [31:0] valid_rdata = '0;
    logic        prev_valid = 1'b0;
    logic        busy_post_valid = 1'b1;
    int tx_stop_bad = 0;
    logic [7:0] tx_q[$];

    udm_host_initiator #(
        .CLK_FREQ_HZ  (25000000),
        .BAUD_RATE    (921600),
        .RESP_TIMEOUT (2000)
    ) dut (
        .clk_i        (clk),
        .arst_i       (arst_i),
        .cmd_req_i    (cmd_req_i),
        .cmd_we_i     (cmd_we_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_wdata_i  (cmd_wdata_i),
        .cmd_ack_o    (cmd_ack_o),
        .resp_valid_o (resp_valid_o),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o),
        .busy_o       (busy_o),
        .rx_i         (rx_i),
        .tx_o         (tx_o)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // event monitor, sampled on the falling edge
    initial forever begin
        @(negedge clk);
        if (cmd_ack_o === 1'b1) begin
            ack_cnt++;
            ack_cyc = cyc;
        end
        if (prev_valid) busy_post_valid = busy_o;
        if (resp_valid_o === 1'b1) begin
            valid_cnt++;
            valid_cyc   = cyc;
            valid_err   = resp_err_o;
            valid_rdata = resp_rdata_o;
        end
        prev_valid = (resp_valid_o === 1'b1);
    end

    // tx_o decoder: mid-bit sampling, pushes each byte into tx_q
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx_o === 1'b0) begin
                repeat (BIT_CYC / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CYC) @(negedge clk);
                    b[i] = tx_o;
                end
                repeat (BIT_CYC) @(negedge clk);
                if (tx_o !== 1'b1) tx_stop_bad++;
                tx_q.push_back(b);
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: sim time expired, got %0d checks expected completion", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int base;
        int n;
        base = ack_cnt;
        n = 0;
        cmd_we_i = we;
        cmd_addr_i = addr;
        cmd_wdata_i = wdata;
        cmd_req_i = 1'b1;
        while (ack_cnt == base && n < 20) begin
            tick();
            n++;
        end
        cmd_req_i = 1'b0;
        chk("ack_seen", 32'(ack_cnt != base), 32'd1);
    endtask

    task automatic wait_valid(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (valid_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(valid_cnt >= target), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_i = 1'b0;
        repeat (BIT_CYC) tick();
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (BIT_CYC) tick();
        end
        rx_i = stop;
        repeat (BIT_CYC) tick();
        rx_i = 1'b1;
    endtask

    task automatic chk_frame(input string tag, input logic [7:0] exp[$]);
        logic [7:0] g;
        chk($sformatf("%s_len", tag), 32'(tx_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            g = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
            chk($sformatf("%s_b%0d", tag, i), 32'(g), 32'(exp[i]));
        end
    endtask

    initial begin
        logic [7:0] exp_q[$];
        int vb;
        int ab;
        int n;
        int first_valid;

        // reset values
        repeat (3) tick();
        chk("rst_tx", 32'(tx_o), 32'd1);
        chk("rst_ack", 32'(cmd_ack_o), 32'd0);
        chk("rst_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_err", 32'(resp_err_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_rdata", resp_rdata_o, 32'd0);
        arst_i = 1'b0;
        repeat (5) tick();

        // write 0x80000000 <= 0xDEADBEEF
        tx_q.delete();
        vb = valid_cnt;
        issue(1'b1, 32'h8000_0000, 32'hDEAD_BEEF);
        chk("wr_busy", 32'(busy_o), 32'd1);
        wait_valid(vb + 1, 5000, "wr_done");
        chk("wr_latency", 32'(valid_cyc - ack_cyc), 32'd3781);
        chk("wr_err", 32'(valid_err), 32'd0);
        exp_q = '{8'h55, 8'h81, 8'h00, 8'h00, 8'h00, 8'h80, 8'h04, 8'h00, 8'h00, 8'h00,
                  8'hEF, 8'hBE, 8'hAD, 8'hDE};
        chk_frame("wr_tx", exp_q);
        tick();
        chk("wr_idle_busy", 32'(busy_o), 32'd0);

        // read 0x00001000, reply 78 56 34 12
        repeat (10) tick();
        tx_q.delete();
        vb = valid_cnt;
        issue(1'b0, 32'h0000_1000, 32'h0);
        n = 0;
        while (tx_q.size() < 10 && n < 4000) begin tick(); n++; end
        repeat (30) tick();
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        wait_valid(vb + 1, 200, "rd_done");
        chk("rd_rdata", valid_rdata, 32'h1234_5678);
        chk("rd_err", 32'(valid_err), 32'd0);
        exp_q = '{8'h55, 8'h80, 8'h00, 8'h10, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
        chk_frame("rd_tx", exp_q);
        repeat (5) tick();
        chk("rd_rdata_hold", resp_rdata_o, 32'h1234_5678);

        // read with no reply: timeout 2000 cycles after the 2700-cycle frame
        repeat (10) tick();
        vb = valid_cnt;
        issue(1'b0, 32'h0000_0020, 32'h0);
        wait_valid(vb + 1, 6000, "to_done");
        chk("to_latency", 32'(valid_cyc - ack_cyc), 32'd4701);
        chk("to_err", 32'(valid_err), 32'd1);

        // read with bad stop bit on the third reply byte
        repeat (10) tick();
        vb = valid_cnt;
        tx_q.delete();
        issue(1'b0, 32'h0000_0040, 32'h0);
        n = 0;
        while (tx_q.size() < 10 && n < 4000) begin tick(); n++; end
        repeat (30) tick();
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b0);
        wait_valid(vb + 1, 200, "fe_done");
        chk("fe_err", 32'(valid_err), 32'd1);
        chk("fe_partial_lo16", valid_rdata & 32'h0000_FFFF, 32'h0000_BBAA);
        repeat (2) tick();
        chk("fe_idle", 32'(busy_o), 32'd0);
        repeat (10) tick();
        vb = valid_cnt;
        issue(1'b1, 32'h0000_0004, 32'h0102_0304);
        wait_valid(vb + 1, 5000, "fe_wr_done");
        chk("fe_wr_latency", 32'(valid_cyc - ack_cyc), 32'd3781);
        chk("fe_wr_err", 32'(valid_err), 32'd0);

        // cmd_req_i held high across two writes
        repeat (10) tick();
        ab = ack_cnt;
        vb = valid_cnt;
        busy_post_valid = 1'b1;
        cmd_we_i = 1'b1;
        cmd_addr_i = 32'h0000_0100;
        cmd_wdata_i = 32'h5555_AAAA;
        cmd_req_i = 1'b1;
        n = 0;
        while (ack_cnt < ab + 2 && n < 12000) begin tick(); n++; end
        cmd_req_i = 1'b0;
        first_valid = valid_cyc;
        chk("hold_second_ack", 32'(ack_cnt - ab), 32'd2);
        chk("hold_first_valid", 32'(valid_cnt - vb), 32'd1);
        chk("hold_ack_gap", 32'(ack_cyc - first_valid), 32'd2);
        chk("hold_busy_gap", 32'(busy_post_valid), 32'd0);
        wait_valid(vb + 2, 5000, "hold_done2");
        repeat (20) tick();
        chk("hold_ack_total", 32'(ack_cnt - ab), 32'd2);

        // reset pulsed during byte 5 of a write
        repeat (10) tick();
        tx_q.delete();
        vb = valid_cnt;
        issue(1'b1, 32'h1111_2222, 32'h3333_4444);
        n = 0;
        while (tx_q.size() < 5 && n < 3000) begin tick(); n++; end
        repeat (40) tick();
        chk("arst_mid_busy_pre", 32'(busy_o), 32'd1);
        arst_i = 1'b1;
        #1;
        chk("arst_tx", 32'(tx_o), 32'd1);
        chk("arst_busy", 32'(busy_o), 32'd0);
        repeat (3) tick();
        arst_i = 1'b0;
        repeat (400) tick();
        chk("arst_no_valid", 32'(valid_cnt - vb), 32'd0);
        tx_q.delete();
        vb = valid_cnt;
        issue(1'b0, 32'h0000_2000, 32'h0);
        n = 0;
        while (tx_q.size() < 10 && n < 4000) begin tick(); n++; end
        repeat (30) tick();
        send_byte(8'h0D, 1'b1);
        send_byte(8'hF0, 1'b1);
        send_byte(8'hFE, 1'b1);
        send_byte(8'hCA, 1'b1);
        wait_valid(vb + 1, 200, "post_rst_rd_done");
        chk("post_rst_rdata", valid_rdata, 32'hCAFE_F00D);
        chk("post_rst_err", 32'(valid_err), 32'd0);
        exp_q = '{8'h55, 8'h80, 8'h00, 8'h20, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
        chk_frame("post_rst_tx", exp_q);
        chk("tx_stop_bits", 32'(tx_stop_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
